gshare_pht: RTL
===============

Name: gshare_pht

Overview:
- Pattern history table for the gshare direction predictor; sits directly downstream of the global history register and consumes its history vector.
- Fetch presents a PC. The table indexes 2-bit saturating counters with PC XOR history and returns a registered taken/not-taken prediction plus the index used.
- The index travels down the pipeline with the branch. EX returns it with the resolved outcome to train the counter.
- After reset, an init sweep writes every counter to weakly-not-taken before accepting requests.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- HISTORY_SIZE, 8, width of the history input; must satisfy 1 <= HISTORY_SIZE <= INDEX_BITS.
- INDEX_BITS, 10, log2 of the table depth; the table holds 2^INDEX_BITS entries of 2 bits each.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  prediction request from fetch.
- req_pc  in  ADDR_WIDTH  PC of the fetched instruction.
- history  in  HISTORY_SIZE  global history from the GHR, bit 0 = most recent outcome.
- req_ready  out  1  high when a request can be accepted (READY state).
- pred_valid  out  1  prediction valid, one-cycle pulse.
- pred_taken  out  1  predicted direction (1 = taken).
- pred_index  out  INDEX_BITS  table index used; carried with the branch to EX.
- upd_valid  in  1  resolved-branch update from EX.
- upd_index  in  INDEX_BITS  index returned from pred_index.
- upd_taken  in  1  resolved outcome.

Behaviour:
- Index = req_pc[INDEX_BITS+1:2] XOR {zeros, history}. History is zero-extended in the upper bits; PC bits [1:0] are ignored.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].

FSM states INIT and READY:
- rst=1 at an edge: state<=INIT, init_ptr<=0, pred_valid<=0, pred_taken<=0, pred_index<=0. req_ready is 0 while in INIT.
- INIT: each cycle writes 01 to entry init_ptr and increments init_ptr. On the cycle that writes entry 2^INDEX_BITS-1, the next state is READY.
  - The sweep takes exactly 2^INDEX_BITS cycles after rst deasserts.
  - req_valid and upd_valid are ignored in INIT, with no table change and no pred_valid.
- READY: req_ready=1. There are no transitions out except rst.
- rst asserted mid-sweep or in READY restarts the sweep at entry 0; any in-flight prediction is dropped (pred_valid<=0).

Prediction (READY):
- Accept at edge N when req_valid&&req_ready.
- At the edge N sample: pred_valid=1, pred_taken=counter[idx][1], pred_index=idx.
- These values are visible during cycle N+1; latency 1, no back-pressure.
- Without an accept at edge N, pred_valid<=0; pred_taken and pred_index hold their last values.

Update (READY, upd_valid=1):
- upd_taken=1 increments counter[upd_index], saturating at 11.
- upd_taken=0 decrements, saturating at 00.
- One update per cycle.
- Update and request in the same cycle to the same index: the prediction reads the pre-update value (read-before-write); the update still commits.
- Update and request to different indices are independent.

Storage:
- Counter storage is never cleared by rst other than through the sweep.
- Contents before sweep completion are don't-care and must not be observable.

Test Plan:
- Init: INDEX_BITS=4. Assert rst 2 cycles, then release. Required: req_ready=0 for exactly 16 cycles, then 1. A request at index 5 yields pred_valid=1, pred_taken=0, pred_index=5 one cycle later.
- Indexing: INDEX_BITS=4, HISTORY_SIZE=3, req_pc=0x0000_0024, history=3'b110. Required: pred_index = 4'b1001 ^ 4'b0110 = 4'hF.
- Saturation: update index 3 taken x3, then request index 3. Required: pred_taken=1. Then 3 not-taken updates: pred_taken=1 after the 1st, 0 after the 2nd and 3rd. A further not-taken update keeps the counter at 00; a single taken update then gives 01, and pred_taken stays 0.
- Collision: counter[7]=01; same cycle req idx 7 + upd idx 7 taken. Required: pred_taken=0 that prediction; next request at 7 gives pred_taken=1.
- Reset mid-sweep: assert rst at sweep cycle 9. Required: req_ready stays 0 for a full 16 further cycles after release. An upd_valid during INIT leaves the target entry at 01.
- Back-to-back: requests on 4 consecutive cycles, all accepted. Required: 4 consecutive pred_valid pulses, each 1 cycle later, indices matching.

Source files
------------

// File: rtl/gshare_pht_if.sv
// gshare PHT port bundle: fetch request/prediction and EX training update.
// master = fetch/EX side, slave = the table.
interface gshare_pht_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int HISTORY_SIZE = 8,
  parameter int INDEX_BITS   = 10
);
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_pc;
  logic [HISTORY_SIZE-1:0] history;
  logic                    req_ready;
  logic                    pred_valid;
  logic                    pred_taken;
  logic [INDEX_BITS-1:0]   pred_index;
  logic                    upd_valid;
  logic [INDEX_BITS-1:0]   upd_index;
  logic                    upd_taken;

  modport master (
    output req_valid, req_pc, history,
    output upd_valid, upd_index, upd_taken,
    input  req_ready, pred_valid,
    input  pred_taken, pred_index
  );

  modport slave (
    input  req_valid, req_pc, history,
    input  upd_valid, upd_index, upd_taken,
    output req_ready, pred_valid,
    output pred_taken, pred_index
  );
endinterface

// File: rtl/gshare_pht.sv
// gshare pattern history table: 2-bit counters indexed by PC ^ history,
// swept to weakly-not-taken after reset, registered prediction, EX training.
module gshare_pht #(
  parameter int ADDR_WIDTH   = 32,
  parameter int HISTORY_SIZE = 8,
  parameter int INDEX_BITS   = 10
) (
  input logic          clk,
  input logic          rst,
  gshare_pht_if.slave  bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST = '1;

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q, state_d;
  logic [1:0]            pht [DEPTH];
  logic [INDEX_BITS-1:0] init_ptr;
  logic [INDEX_BITS-1:0] hist_ext;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  accept;
  logic [1:0]            upd_cnt;
  logic [1:0]            upd_next;
  logic                  we;
  logic [INDEX_BITS-1:0] waddr;
  logic [1:0]            wdata;
  logic                  pc_unused;

  assign hist_ext = INDEX_BITS'(bus.history);
  assign req_idx  = bus.req_pc[INDEX_BITS+1:2] ^ hist_ext;
  assign bus.req_ready = (state_q == READY);
  assign accept   = bus.req_valid && bus.req_ready;
  assign upd_cnt  = pht[bus.upd_index];

  assign pc_unused = &{1'b0,
    bus.req_pc[ADDR_WIDTH-1:INDEX_BITS+2],
    bus.req_pc[1:0]};

  always_comb begin
    upd_next = upd_cnt;
    unique case (1'b1)
      bus.upd_taken && upd_cnt != 2'b11:
        upd_next = upd_cnt + 2'd1;
      !bus.upd_taken && upd_cnt != 2'b00:
        upd_next = upd_cnt - 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = init_ptr;
    wdata   = 2'b01;
    unique case (state_q)
      INIT: begin
        we = 1'b1;
        if (init_ptr == LAST) state_d = READY;
      end
      READY: begin
        we    = bus.upd_valid;
        waddr = bus.upd_index;
        wdata = upd_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      init_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT)
        init_ptr <= init_ptr + INDEX_BITS'(1);
    end
  end

  // Read-before-write: the prediction samples the old counter value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_index <= '0;
    end else begin
      bus.pred_valid <= accept;
      if (accept) begin
        bus.pred_taken <= pht[req_idx][1];
        bus.pred_index <= req_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst)
      pht[waddr] <= wdata;
  end
endmodule
